gpu_axil_writer: RTL and testbench
==================================

GPU_AXIL_WRITER -- requirements
Module: gpu_axil_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, AXI-Lite and command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite and command data width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cmd_addr, input, ADDR_WIDTH, GPU byte address of the write.
REQ-008 SHALL have port cmd_data, input, DATA_WIDTH, write data.
REQ-009 SHALL have port cmd_valid, input, 1, command offered.
REQ-010 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both 1.
REQ-011 SHALL have ports axil_awaddr (output, ADDR_WIDTH), axil_awprot (output, 3), axil_awvalid (output, 1) and axil_awready (input, 1).
REQ-012 SHALL have ports axil_wdata (output, DATA_WIDTH), axil_wstrb (output, STRB_WIDTH), axil_wvalid (output, 1) and axil_wready (input, 1).
REQ-013 SHALL have ports axil_bresp (input, 2), axil_bvalid (input, 1) and axil_bready (output, 1).
REQ-014 SHALL have port busy, output, 1, high when the FIFO is non-empty or a transaction is in flight.
REQ-015 SHALL have port err_count, output, 16, count of responses with non-OKAY bresp.

Function
REQ-016 SHALL buffer accepted commands in FIFO order; cmd_ready = 1 exactly when the FIFO holds fewer than FIFO_DEPTH entries, with no bypass path.
REQ-017 SHALL allow a push and a pop in the same cycle when not full; the occupancy then stays unchanged.
REQ-018 SHALL use the FSM states IDLE, SEND and RESP.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop the head entry into registered awaddr/wdata, set axil_awvalid = axil_wvalid = 1 on the next cycle, and enter SEND.
REQ-020 SHALL give a minimum latency of one cycle from command acceptance into an empty FIFO to axil_awvalid = 1.
REQ-021 SHALL, in SEND, clear axil_awvalid on the cycle after its handshake and clear axil_wvalid on the cycle after its handshake, independently, in either order or together.
REQ-022 SHALL, in SEND, hold axil_awaddr and axil_wdata stable while the corresponding valid is high; valid never drops before its ready.
REQ-023 SHALL enter RESP once both handshakes have completed, and drive axil_bready = 1 only in RESP.
REQ-024 SHALL, in RESP, complete on axil_bvalid = 1 and then go to IDLE, or go directly to the next SEND if the FIFO is non-empty, with no idle cycle.
REQ-025 SHALL keep at most one write outstanding.
REQ-026 SHALL drive axil_awprot = 3'b000 and axil_wstrb = all ones at all times.
REQ-027 SHALL increment err_count when a response completes with axil_bresp != 2'b00, saturating at 16'hFFFF.
REQ-028 SHALL ignore axil_bvalid outside RESP.
REQ-029 SHALL drive busy combinationally as (FIFO non-empty) OR (state != IDLE).

Reset
REQ-030 SHALL, while rst = 0, asynchronously force state = IDLE, FIFO empty, axil_awvalid = axil_wvalid = axil_bready = 0, axil_awaddr = axil_wdata = 0 and err_count = 0.
REQ-031 SHALL, on reset assertion mid-transaction, discard the FIFO contents and the in-flight write without issuing a response.
REQ-032 SHALL hold cmd_ready = 0 while rst = 0, and release it on the first clk edge after deassertion.

Verification
REQ-033 Single write with awready = wready = bvalid = 1 tied high; push addr 0x000010, data 0x00000ABC -> awvalid and wvalid rise 1 cycle later carrying 0x000010 and 0x00000ABC, bready pulses, busy falls, err_count = 0.
REQ-034 Skewed handshakes: wready asserted 3 cycles before awready -> wvalid drops the cycle after its handshake, awvalid holds until its own handshake, and exactly one write is issued.
REQ-035 FIFO full: awready held at 0 while 9 commands are pushed (FIFO_DEPTH = 8) -> cmd_ready = 0 after the 8th accept, plus the one in flight; all 9 writes then emerge in order once awready = 1.
REQ-036 Error count: bresp = 2'b10 on 3 consecutive responses -> err_count = 3; preload err_count to 0xFFFF and give one error response -> err_count stays 0xFFFF.
REQ-037 Reset mid-operation: assert rst = 0 while in SEND with 4 entries queued -> all valids are 0 immediately, busy = 0, and no writes appear after release.
REQ-038 Back-to-back: push 4 commands with bvalid = 1 tied high -> no IDLE cycle between RESP and the next SEND, with one write every 3 cycles.

Source files
------------

// File: rtl/gpu_axil_writer.sv
// rtl/gpu_axil_writer.sv - queued GPU write commands issued one at a time over AXI-Lite
module gpu_axil_writer #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] axil_awaddr,
   output logic [2:0]            axil_awprot,
   output logic                  axil_awvalid,
   input  logic                  axil_awready,
   output logic [DATA_WIDTH-1:0] axil_wdata,
   output logic [STRB_WIDTH-1:0] axil_wstrb,
   output logic                  axil_wvalid,
   input  logic                  axil_wready,
   input  logic [1:0]            axil_bresp,
   input  logic                  axil_bvalid,
   output logic                  axil_bready,
   output logic                  busy,
   output logic [15:0]           err_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   state_t                 state;
   logic [ENT_W-1:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   logic                   ready_en;
   logic                   empty;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic [ENT_W-1:0]       head;
   logic [15:0]            err_cnt;

   assign empty       = (count == '0);
   assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
   // ready_en keeps cmd_ready low until the first edge after reset release
   assign cmd_ready   = ready_en && !full;
   assign push        = cmd_valid && cmd_ready;
   assign pop         = !empty && ((state == IDLE) || (state == RESP && axil_bvalid));
   assign head        = mem[rd_ptr];
   assign axil_awprot = 3'b000;
   assign axil_wstrb  = '1;
   assign busy        = !empty || (state != IDLE);
   assign err_count   = err_cnt;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_addr, cmd_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         axil_awaddr  <= '0;
         axil_wdata   <= '0;
         axil_awvalid <= 1'b0;
         axil_wvalid  <= 1'b0;
         axil_bready  <= 1'b0;
         err_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  axil_awaddr  <= head[ENT_W-1:DATA_WIDTH];
                  axil_wdata   <= head[DATA_WIDTH-1:0];
                  axil_awvalid <= 1'b1;
                  axil_wvalid  <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (axil_awvalid && axil_awready) axil_awvalid <= 1'b0;
               if (axil_wvalid && axil_wready)   axil_wvalid  <= 1'b0;
               // both channels have already dropped valid: wait for the response
               if (!axil_awvalid && !axil_wvalid) begin
                  axil_bready <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (axil_bvalid) begin
                  axil_bready <= 1'b0;
                  if (axil_bresp != 2'b00 && err_cnt != 16'hFFFF) begin
                     err_cnt <= err_cnt + 16'd1;
                  end
                  if (pop) begin
                     axil_awaddr  <= head[ENT_W-1:DATA_WIDTH];
                     axil_wdata   <= head[DATA_WIDTH-1:0];
                     axil_awvalid <= 1'b1;
                     axil_wvalid  <= 1'b1;
                     state        <= SEND;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_axil_writer.sv
// tb/tb_gpu_axil_writer.sv - scoreboard bench for gpu_axil_writer
module tb_gpu_axil_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [23:0] axil_awaddr;
   logic [2:0]  axil_awprot;
   logic        axil_awvalid;
   logic        axil_awready = 1'b0;
   logic [31:0] axil_wdata;
   logic [3:0]  axil_wstrb;
   logic        axil_wvalid;
   logic        axil_wready = 1'b0;
   logic [1:0]  axil_bresp = 2'b00;
   logic        axil_bvalid = 1'b0;
   logic        axil_bready;
   logic        busy;
   logic [15:0] err_count;

   gpu_axil_writer dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot), .axil_awvalid(axil_awvalid),
      .axil_awready(axil_awready),
      .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid),
      .axil_wready(axil_wready),
      .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
      .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          n_writes = 0;
   int          cyc = 0;
   logic [55:0] exp_q [$];
   logic [23:0] aw_q [$];
   logic [31:0] w_q [$];
   int          hs_cyc [$];
   logic        aw_pend = 1'b0;
   logic        w_pend = 1'b0;
   logic [23:0] last_awaddr = '0;
   logic [31:0] last_wdata = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // monitor: pairs AW and W handshakes and compares against the expected queue
   always @(negedge clk) begin
      logic [55:0] e;
      cyc++;
      if (rst) begin
         if (aw_pend && axil_awvalid) check("awaddr_stable", 64'(axil_awaddr), 64'(last_awaddr));
         if (w_pend && axil_wvalid)   check("wdata_stable", 64'(axil_wdata), 64'(last_wdata));
         check("awprot_wstrb", {57'd0, axil_awprot, axil_wstrb}, 64'h0F);
         if (axil_awvalid && axil_awready) begin
            aw_q.push_back(axil_awaddr);
            hs_cyc.push_back(cyc);
         end
         if (axil_wvalid && axil_wready) w_q.push_back(axil_wdata);
         while (aw_q.size() > 0 && w_q.size() > 0) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", {8'd0, aw_q[0], w_q[0]}, 64'hDEAD_DEAD);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 64'(aw_q[0]), 64'(e[55:32]));
               check("write_data", 64'(w_q[0]), 64'(e[31:0]));
            end
            void'(aw_q.pop_front());
            void'(w_q.pop_front());
         end
      end
      aw_pend     = axil_awvalid && !axil_awready;
      w_pend      = axil_wvalid && !axil_wready;
      last_awaddr = axil_awaddr;
      last_wdata  = axil_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [23:0] a, input logic [31:0] d);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         check("push_timeout", 64'd1, 64'd0);
      end else begin
         cmd_addr  = a;
         cmd_data  = d;
         cmd_valid = 1'b1;
         exp_q.push_back({a, d});
         tick();
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check("idle_timeout", 64'(busy), 64'd0);
   endtask

   initial begin
      int base;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_valids", {61'd0, axil_awvalid, axil_wvalid, axil_bready}, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_count), 64'd0);
      rst = 1'b1;
      #1;
      check("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
      tick();
      check("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

      // single write, everything tied ready
      axil_awready = 1'b1; axil_wready = 1'b1; axil_bvalid = 1'b1;
      push(24'h000010, 32'h00000ABC);
      check("single_lat0_awvalid", 64'(axil_awvalid), 64'd0);
      check("single_busy", 64'(busy), 64'd1);
      tick();
      check("single_valids", {62'd0, axil_awvalid, axil_wvalid}, 64'd3);
      check("single_awaddr", 64'(axil_awaddr), 64'h10);
      check("single_wdata", 64'(axil_wdata), 64'hABC);
      tick();
      check("single_valids_drop", {62'd0, axil_awvalid, axil_wvalid}, 64'd0);
      tick();
      check("single_bready", 64'(axil_bready), 64'd1);
      tick();
      check("single_bready_off", 64'(axil_bready), 64'd0);
      check("single_busy_off", 64'(busy), 64'd0);
      check("single_err", 64'(err_count), 64'd0);

      // skewed handshakes: wready three cycles ahead of awready
      axil_awready = 1'b0; axil_wready = 1'b0; axil_bvalid = 1'b0;
      base = n_writes;
      push(24'h000020, 32'h00001111);
      tick();
      check("skew_valids", {62'd0, axil_awvalid, axil_wvalid}, 64'd3);
      axil_wready = 1'b1;
      tick();
      axil_wready = 1'b0;
      check("skew_w_dropped", {62'd0, axil_awvalid, axil_wvalid}, 64'd2);
      tick();
      check("skew_aw_held", 64'(axil_awvalid), 64'd1);
      tick();
      axil_awready = 1'b1;
      tick();
      axil_awready = 1'b0;
      check("skew_aw_dropped", 64'(axil_awvalid), 64'd0);
      axil_bvalid = 1'b1;
      wait_idle();
      axil_bvalid = 1'b0;
      check("skew_one_write", 64'(n_writes - base), 64'd1);

      // FIFO full while the head write is stuck on awready
      axil_wready = 1'b1; axil_bvalid = 1'b1;
      base = n_writes;
      for (int i = 0; i < 9; i++) push(24'h000100 + 24'(i * 4), 32'hC0DE_0000 + 32'(i));
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_busy", 64'(busy), 64'd1);
      check("full_held", 64'(axil_awaddr), 64'h100);
      axil_awready = 1'b1;
      wait_idle();
      check("full_nine_writes", 64'(n_writes - base), 64'd9);

      // error counting and saturation
      axil_bresp = 2'b10;
      for (int i = 0; i < 3; i++) push(24'h000200 + 24'(i), 32'hE000_0000 + 32'(i));
      wait_idle();
      check("err_three", 64'(err_count), 64'd3);
      force dut.err_cnt = 16'hFFFF;
      tick();
      release dut.err_cnt;
      push(24'h000300, 32'h0000EEEE);
      wait_idle();
      check("err_saturate", 64'(err_count), 64'hFFFF);
      axil_bresp = 2'b00;

      // reset in the middle of a queued burst
      axil_awready = 1'b0; axil_wready = 1'b0; axil_bvalid = 1'b0;
      for (int i = 0; i < 5; i++) push(24'h000400 + 24'(i), 32'hAAAA_0000 + 32'(i));
      check("mid_queued_busy", 64'(busy), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_valids", {61'd0, axil_awvalid, axil_wvalid, axil_bready}, 64'd0);
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_cmd_ready", 64'(cmd_ready), 64'd0);
      check("mid_err", 64'(err_count), 64'd0);
      check("mid_addr_data", {8'd0, axil_awaddr, axil_wdata}, 64'd0);
      exp_q.delete(); aw_q.delete(); w_q.delete();
      axil_awready = 1'b1; axil_wready = 1'b1; axil_bvalid = 1'b1;
      base = n_writes;
      tick();
      rst = 1'b1;
      repeat (20) tick();
      check("mid_no_writes", 64'(n_writes - base), 64'd0);
      check("mid_idle", 64'(busy), 64'd0);

      // back-to-back: one write every three cycles
      hs_cyc.delete();
      for (int i = 0; i < 4; i++) push(24'h000500 + 24'(i * 8), 32'hB2B0_0000 + 32'(i));
      wait_idle();
      check("b2b_count", 64'(hs_cyc.size()), 64'd4);
      if (hs_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) check("b2b_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
